mode_det_param: RTL and testbench

//  Parametrised serial test-mode/key detector plus mode-select decoder for the EEPROM digital core.

---
 rtl/mode_det_param.sv | 197 +++++++++++++++++++
 tb/tb_mode_det_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_det_param.sv
// -----------------------------------------------------------------------------
// mode_det_param
// Serial test-mode key detector and mode-select decoder for the EEPROM core.
// While a0_csbar is low, each rising edge samples a2_wpbar. A KEY_W-bit key
// enables test mode. After that, (MODE_W+1)-bit frames (code MSB first, then
// an odd-parity bit) select one of MODE_NUM modes. A partial frame is dropped
// after TO_MAX idle edges (a0_csbar high).
//
// Ports
//   mode_cfg_clk   in   1       clock, all state on rising edge
//   por_rst_n      in   1       asynchronous active-low power-on reset
//   a0_csbar       in   1       sample enable, active low
//   a2_wpbar       in   1       serial data bit
//   ee_wbusy_comb  in   1       EE write busy, clears key shifter while hunting
//   test_disable   in   1       synchronous exit from test mode (clears all)
//   test_en        out  1       test mode active
//   mode_val       out  1       mode_sel holds a validated mode
//   mode_sel       out  MODE_W  selected mode code
//   mode_err       out  1       last completed frame failed parity/range check
// -----------------------------------------------------------------------------
module mode_det_param #(
    parameter int unsigned       KEY_W    = 8,
    parameter logic [KEY_W-1:0]  KEY_SEQ  = 8'hD2,
    parameter int unsigned       MODE_W   = 3,
    parameter int unsigned       MODE_NUM = 5,
    parameter int unsigned       TO_W     = 8,
    parameter int unsigned       TO_MAX   = 200
) (
    input  logic              mode_cfg_clk,
    input  logic              por_rst_n,
    input  logic              a0_csbar,
    input  logic              a2_wpbar,
    input  logic              ee_wbusy_comb,
    input  logic              test_disable,
    output logic              test_en,
    output logic              mode_val,
    output logic [MODE_W-1:0] mode_sel,
    output logic              mode_err
);

    localparam int unsigned CNT_W = $clog2(MODE_W + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(MODE_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TO_W-1:0]   TO_LIM   = TO_W'(TO_MAX);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    localparam logic [MODE_W:0]   CODE_LIM = (MODE_W + 1)'(MODE_NUM);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_CODE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

    // A frame is accepted when the parity over code and parity bit is odd
    // and the code is one of the legal modes.
    function automatic logic frame_ok(input logic [MODE_W:0] frame);
        logic             par_ok;
        logic [MODE_W:0]  code_ext;
        par_ok   = ^frame;
        code_ext = {1'b0, frame[MODE_W:1]};
        return par_ok & (code_ext < CODE_LIM);
    endfunction

    state_e              state_q,    state_d;
    logic [KEY_W-1:0]    key_sr_q,   key_sr_d;
    logic [MODE_W-1:0]   frame_sr_q, frame_sr_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;
    logic                test_en_q,  test_en_d;
    logic                mode_val_q, mode_val_d;
    logic [MODE_W-1:0]   mode_sel_q, mode_sel_d;
    logic                mode_err_q, mode_err_d;

    logic                sample_s;
    logic [KEY_W:0]      key_s;
    logic [MODE_W:0]     frame_s;

    // Next-state and output decode for the hunt/code/active machine.
    always_comb begin
        state_d    = state_q;
        key_sr_d   = key_sr_q;
        frame_sr_d = frame_sr_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = to_cnt_q;
        test_en_d  = test_en_q;
        mode_val_d = mode_val_q;
        mode_sel_d = mode_sel_q;
        mode_err_d = mode_err_q;

        sample_s = ~a0_csbar;
        key_s    = {key_sr_q, a2_wpbar};
        frame_s  = {frame_sr_q, a2_wpbar};

        if (test_disable) begin
            // Exit wins over everything, including a key match on this edge.
            state_d    = S_HUNT;
            key_sr_d   = '0;
            bit_cnt_d  = '0;
            to_cnt_d   = '0;
            test_en_d  = 1'b0;
            mode_val_d = 1'b0;
            mode_sel_d = '0;
            mode_err_d = 1'b0;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (ee_wbusy_comb) begin
                        key_sr_d = '0;
                    end else if (sample_s) begin
                        key_sr_d = key_s[KEY_W-1:0];
                        if (key_s[KEY_W-1:0] == KEY_SEQ) begin
                            test_en_d = 1'b1;
                            bit_cnt_d = '0;
                            to_cnt_d  = '0;
                            state_d   = S_CODE;
                        end else begin
                            state_d = S_HUNT;
                        end
                    end else begin
                        state_d = S_HUNT;
                    end
                end
                S_CODE, S_ACTIVE: begin
                    if (sample_s) begin
                        to_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            if (frame_ok(frame_s)) begin
                                mode_sel_d = frame_s[MODE_W:1];
                                mode_val_d = 1'b1;
                                mode_err_d = 1'b0;
                                state_d    = S_ACTIVE;
                            end else begin
                                mode_err_d = 1'b1;
                            end
                        end else begin
                            frame_sr_d = frame_s[MODE_W-1:0];
                            bit_cnt_d  = bit_cnt_q + CNT_ONE;
                        end
                    end else if (bit_cnt_q != '0) begin
                        // Idle inside a frame: drop the partial frame after TO_MAX edges.
                        if ((to_cnt_q + TO_ONE) == TO_LIM) begin
                            bit_cnt_d = '0;
                            to_cnt_d  = '0;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_ONE;
                        end
                    end else begin
                        to_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = S_HUNT;
                    key_sr_d   = '0;
                    bit_cnt_d  = '0;
                    to_cnt_d   = '0;
                    test_en_d  = 1'b0;
                    mode_val_d = 1'b0;
                    mode_sel_d = '0;
                    mode_err_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous power-on reset.
    always_ff @(posedge mode_cfg_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            state_q    <= S_HUNT;
            key_sr_q   <= '0;
            frame_sr_q <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            test_en_q  <= 1'b0;
            mode_val_q <= 1'b0;
            mode_sel_q <= '0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_sr_q   <= key_sr_d;
            frame_sr_q <= frame_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            test_en_q  <= test_en_d;
            mode_val_q <= mode_val_d;
            mode_sel_q <= mode_sel_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign test_en  = test_en_q;
    assign mode_val = mode_val_q;
    assign mode_sel = mode_sel_q;
    assign mode_err = mode_err_q;

endmodule

// File: tb/tb_mode_det_param.sv
module tb_mode_det_param;

    localparam int          KEY_W    = 8;
    localparam logic [7:0]  KEY_SEQ  = 8'hD2;
    localparam int          MODE_W   = 3;
    localparam int          MODE_NUM = 5;
    localparam int          TO_W     = 8;
    localparam int          TO_MAX   = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic csb   = 1'b1;
    logic d     = 1'b0;
    logic busy  = 1'b0;
    logic dis   = 1'b0;

    logic              test_en;
    logic              mode_val;
    logic [MODE_W-1:0] mode_sel;
    logic              mode_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mode_det_param #(
        .KEY_W(KEY_W), .KEY_SEQ(KEY_SEQ), .MODE_W(MODE_W),
        .MODE_NUM(MODE_NUM), .TO_W(TO_W), .TO_MAX(TO_MAX)
    ) dut (
        .mode_cfg_clk (clk),
        .por_rst_n    (rst_n),
        .a0_csbar     (csb),
        .a2_wpbar     (d),
        .ee_wbusy_comb(busy),
        .test_disable (dis),
        .test_en      (test_en),
        .mode_val     (mode_val),
        .mode_sel     (mode_sel),
        .mode_err     (mode_err)
    );

    // ---------------- behavioural model ----------------
    int m_hist;        // last KEY_W sampled key bits as a number
    bit m_test;
    bit m_val;
    bit m_err;
    int m_sel;
    bit fq[$];         // bits of the frame collected so far
    int m_idle;

    function automatic void model_reset();
        m_hist = 0; m_test = 0; m_val = 0; m_err = 0; m_sel = 0;
        fq.delete(); m_idle = 0;
    endfunction

    function automatic void model_step(bit c, bit dd, bit b, bit ds);
        int code;
        int ones;
        if (ds) begin
            model_reset();
        end else if (!m_test) begin
            if (b) m_hist = 0;
            else if (!c) begin
                m_hist = (m_hist * 2 + int'(dd)) % (1 << KEY_W);
                if (m_hist == int'(KEY_SEQ)) begin
                    m_test = 1; fq.delete(); m_idle = 0;
                end
            end
        end else begin
            if (!c) begin
                fq.push_back(dd);
                m_idle = 0;
                if (fq.size() == MODE_W + 1) begin
                    code = 0; ones = 0;
                    for (int i = 0; i < MODE_W; i++) code = code * 2 + int'(fq[i]);
                    for (int i = 0; i <= MODE_W; i++) ones += int'(fq[i]);
                    if ((ones % 2) == 1 && code < MODE_NUM) begin
                        m_sel = code; m_val = 1; m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                    fq.delete();
                end
            end else if (fq.size() != 0) begin
                m_idle++;
                if (m_idle == TO_MAX) begin
                    fq.delete(); m_idle = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    initial model_reset();
    always @(negedge rst_n) model_reset();

    // Cycle-by-cycle comparison against the model.
    initial begin
        bit c, dd, b, ds;
        forever begin
            @(posedge clk);
            c = csb; dd = d; b = busy; ds = dis;
            if (!rst_n) model_reset();
            else model_step(c, dd, b, ds);
            #1;
            chk("test_en",  {31'd0, test_en},  {31'd0, m_test});
            chk("mode_val", {31'd0, mode_val}, {31'd0, m_val});
            chk("mode_sel", {29'd0, mode_sel}, m_sel);
            chk("mode_err", {31'd0, mode_err}, {31'd0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit c, input bit dd, input bit b, input bit ds);
        @(negedge clk);
        csb = c; d = dd; busy = b; dis = ds;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input bit dd);
        cyc(1'b0, dd, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_key();
        logic [KEY_W-1:0] k;
        k = KEY_SEQ;
        for (int i = KEY_W - 1; i >= 0; i--) send(k[i]);
    endtask

    task automatic frame(input logic [3:0] f);
        for (int i = 3; i >= 0; i--) send(f[i]);
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        int r;
        k = KEY_SEQ;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_test_en", {31'd0, test_en}, 32'd0);
        chk("rst_mode_sel", {29'd0, mode_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // key 1,1,0,1,0,0,1,0
        for (int i = KEY_W - 1; i >= 1; i--) send(k[i]);
        chk("key7_test_en", {31'd0, test_en}, 32'd0);
        send(k[0]);
        chk("key8_test_en", {31'd0, test_en}, 32'd1);
        chk("key8_mode_val", {31'd0, mode_val}, 32'd0);

        // code 2, parity 0 -> valid
        frame(4'b0100);
        chk("f2_sel", {29'd0, mode_sel}, 32'd2);
        chk("f2_val", {31'd0, mode_val}, 32'd1);
        chk("f2_err", {31'd0, mode_err}, 32'd0);

        // code 6 out of range
        frame(4'b1101);
        chk("f6_err", {31'd0, mode_err}, 32'd1);
        chk("f6_sel", {29'd0, mode_sel}, 32'd2);
        chk("f6_val", {31'd0, mode_val}, 32'd1);
        // even parity -> rejected
        frame(4'b0110);
        chk("badpar_err", {31'd0, mode_err}, 32'd1);
        frame(4'b1000);
        chk("f4_sel", {29'd0, mode_sel}, 32'd4);
        chk("f4_err", {31'd0, mode_err}, 32'd0);

        // timeout of exactly TO_MAX drops the partial frame
        send(1'b0); send(1'b1);
        idle(TO_MAX);
        frame(4'b0111);
        chk("to_sel", {29'd0, mode_sel}, 32'd3);
        chk("to_err", {31'd0, mode_err}, 32'd0);
        // one short of the timeout keeps the stale bits -> 1,1,0,1 misaligned
        send(1'b1); send(1'b1);
        idle(TO_MAX - 1);
        frame(4'b0111);
        chk("to199_err", {31'd0, mode_err}, 32'd1);
        chk("to199_sel", {29'd0, mode_sel}, 32'd3);

        // exit from active test mode
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("dis_test_en", {31'd0, test_en}, 32'd0);
        chk("dis_val", {31'd0, mode_val}, 32'd0);
        chk("dis_sel", {29'd0, mode_sel}, 32'd0);

        // busy pulse in the middle of the key
        for (int i = KEY_W - 1; i >= 2; i--) send(k[i]);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        send(k[1]); send(k[0]);
        chk("busy_test_en", {31'd0, test_en}, 32'd0);

        // test_disable on the matching edge
        idle(2);
        for (int i = KEY_W - 1; i >= 1; i--) send(k[i]);
        cyc(1'b0, k[0], 1'b0, 1'b1);
        chk("dis_match_test_en", {31'd0, test_en}, 32'd0);

        // async reset mid-frame
        send_key();
        chk("rekey_test_en", {31'd0, test_en}, 32'd1);
        frame(4'b0001);
        send(1'b1); send(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_test_en", {31'd0, test_en}, 32'd0);
        chk("arst_val", {31'd0, mode_val}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int it = 0; it < 100; it++) begin
            if ($urandom_range(0, 1) == 1) send_key();
            for (int j = 0; j < 40; j++) begin
                r = $urandom_range(0, 99);
                if (r < 3) idle($urandom_range(TO_MAX - 5, TO_MAX + 5));
                else cyc((r < 70) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
            end
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
